// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU clients and alu_arbiter.
// The master side is the pair of clients and the slave side is the arbiter.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [1:0]  req0_width;
    logic        req0_sat;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [1:0]  req1_width;
    logic        req1_sat;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp_data;

    modport master (
        output req0_valid, req0_a, req0_b, req0_width, req0_sat,
        output req1_valid, req1_a, req1_b, req1_width, req1_sat,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data,
        output rsp0_ready, rsp1_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_width, req0_sat,
        input  req1_valid, req1_a, req1_b, req1_width, req1_sat,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data,
        input  rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one packed-SIMD saturating adder between two clients.
// Define ALU_ARB_STATS_EN to enable the saturating per-requester grant counters.
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  width,
    input  logic        sat,
    output logic [31:0] c
);
    // Signed saturation: overflow only when both operands share a sign the sum lacks.
    function automatic logic [7:0] add8(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic [7:0] sum;
        sum = x + y;
        if (s && (x[7] == y[7]) && (sum[7] != x[7]))
            add8 = x[7] ? 8'h80 : 8'h7F;
        else
            add8 = sum;
    endfunction

    function automatic logic [15:0] add16(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [15:0] sum;
        sum = x + y;
        if (s && (x[15] == y[15]) && (sum[15] != x[15]))
            add16 = x[15] ? 16'h8000 : 16'h7FFF;
        else
            add16 = sum;
    endfunction

    function automatic logic [31:0] add32(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [31:0] sum;
        sum = x + y;
        if (s && (x[31] == y[31]) && (sum[31] != x[31]))
            add32 = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else
            add32 = sum;
    endfunction

    // Width code 11 is reserved and falls through to the full 32-bit add.
    always_comb begin
        c = '0;
        case (width)
            2'b00: begin
                for (int i = 0; i < 4; i++)
                    c[i*8 +: 8] = add8(a[i*8 +: 8], b[i*8 +: 8], sat);
            end
            2'b01: begin
                for (int i = 0; i < 2; i++)
                    c[i*16 +: 16] = add16(a[i*16 +: 16], b[i*16 +: 16], sat);
            end
            default: c = add32(a, b, sat);
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);
    logic [31:0] res;
    logic        res_valid;
    logic        res_owner;
    logic        last;

    logic        grant_valid;
    logic        grant;
    logic        rsp_fire;
    logic        can_accept;
    logic        accept;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_width;
    logic        alu_sat;
    logic [31:0] alu_c;

    // On a tie the requester that was not granted most recently wins.
    always_comb begin
        grant_valid = bus.req0_valid | bus.req1_valid;
        grant       = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            grant = ~last;
        else if (bus.req1_valid)
            grant = 1'b1;
    end

    assign rsp_fire   = res_valid & (res_owner ? bus.rsp1_ready : bus.rsp0_ready);
    assign can_accept = ~res_valid | rsp_fire;
    assign accept     = can_accept & grant_valid;

    assign bus.req0_ready = accept & ~grant;
    assign bus.req1_ready = accept & grant;

    assign alu_a     = grant ? bus.req1_a     : bus.req0_a;
    assign alu_b     = grant ? bus.req1_b     : bus.req0_b;
    assign alu_width = grant ? bus.req1_width : bus.req0_width;
    assign alu_sat   = grant ? bus.req1_sat   : bus.req0_sat;

    alu u_alu (
        .a     (alu_a),
        .b     (alu_b),
        .width (alu_width),
        .sat   (alu_sat),
        .c     (alu_c)
    );

    // A fresh accept always takes precedence, so a firing response can be replaced back-to-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res       <= '0;
            res_valid <= 1'b0;
            res_owner <= 1'b0;
            last      <= 1'b1;
        end else if (accept) begin
            res       <= alu_c;
            res_valid <= 1'b1;
            res_owner <= grant;
            last      <= grant;
        end else if (rsp_fire) begin
            res_valid <= 1'b0;
        end
    end

    assign bus.rsp0_valid = res_valid & ~res_owner;
    assign bus.rsp1_valid = res_valid & res_owner;
    assign bus.rsp_data   = res;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (accept) begin
            if (!grant && cnt0 != '1)
                cnt0 <= cnt0 + 1'b1;
            if (grant && cnt1 != '1)
                cnt1 <= cnt1 + 1'b1;
        end
    end

    assign gnt_cnt0 = cnt0;
    assign gnt_cnt1 = cnt1;
`else
    assign gnt_cnt0 = '0;
    assign gnt_cnt1 = '0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (CNT_W=4); stats expectations follow ALU_ARB_STATS_EN.
module tb_alu_arbiter;
    localparam int CNT_W = 4;
`ifdef ALU_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;
    int               checks_total;
    int               fail_count;

    alu_arbiter_if bus ();

    alu_arbiter #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic drive_req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] w, input logic s);
        bus.req0_valid = v;
        bus.req0_a     = a;
        bus.req0_b     = b;
        bus.req0_width = w;
        bus.req0_sat   = s;
    endtask

    task automatic drive_req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] w, input logic s);
        bus.req1_valid = v;
        bus.req1_a     = a;
        bus.req1_b     = b;
        bus.req1_width = w;
        bus.req1_sat   = s;
    endtask

    initial begin
        checks_total = 0;
        fail_count   = 0;
        rst_n        = 1'b0;
        drive_req0(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        drive_req1(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_rsp0_valid", 32'(bus.rsp0_valid), 32'h0);
        check_output("reset_rsp1_valid", 32'(bus.rsp1_valid), 32'h0);
        check_output("reset_rsp_data", bus.rsp_data, 32'h0);
        check_output("reset_req0_ready", 32'(bus.req0_ready), 32'h0);
        check_output("reset_gnt_cnt0", 32'(gnt_cnt0), 32'h0);
        check_output("reset_gnt_cnt1", 32'(gnt_cnt1), 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Single request on requester 0, 32-bit wrapping add
        @(negedge clk);
        drive_req0(1'b1, 32'h0000_00FF, 32'h0000_0001, 2'b10, 1'b0);
        #1;
        check_output("single_req0_ready", 32'(bus.req0_ready), 32'h1);
        check_output("single_req1_ready", 32'(bus.req1_ready), 32'h0);
        @(posedge clk);
        #1;
        drive_req0(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        check_output("single_rsp0_valid", 32'(bus.rsp0_valid), 32'h1);
        check_output("single_rsp_data", bus.rsp_data, 32'h0000_0100);
        check_output("single_rsp1_valid", 32'(bus.rsp1_valid), 32'h0);
        @(negedge clk) bus.rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("single_rsp0_drained", 32'(bus.rsp0_valid), 32'h0);
        bus.rsp0_ready = 1'b0;

        // Requester 1, 8-bit lanes, saturating then wrapping
        @(negedge clk);
        drive_req1(1'b1, 32'h7F7F_7F7F, 32'h0101_0101, 2'b00, 1'b1);
        bus.rsp1_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("lane8_sat_valid", 32'(bus.rsp1_valid), 32'h1);
        check_output("lane8_sat_data", bus.rsp_data, 32'h7F7F_7F7F);
        drive_req1(1'b1, 32'h7F7F_7F7F, 32'h0101_0101, 2'b00, 1'b0);
        #1;
        check_output("lane8_b2b_ready", 32'(bus.req1_ready), 32'h1);
        @(posedge clk);
        #1;
        check_output("lane8_wrap_data", bus.rsp_data, 32'h8080_8080);
        check_output("lane8_wrap_valid", 32'(bus.rsp1_valid), 32'h1);
        drive_req1(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        @(posedge clk);
        #1;
        check_output("lane8_drained", 32'(bus.rsp1_valid), 32'h0);
        bus.rsp1_ready = 1'b0;

        // Requester 0: 16-bit lanes, reserved width, negative saturation
        @(negedge clk);
        drive_req0(1'b1, 32'h7FFF_8000, 32'h0001_FFFF, 2'b01, 1'b1);
        bus.rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("lane16_sat_data", bus.rsp_data, 32'h7FFF_8000);
        drive_req0(1'b1, 32'h7FFF_8000, 32'h0001_FFFF, 2'b01, 1'b0);
        @(posedge clk);
        #1;
        check_output("lane16_wrap_data", bus.rsp_data, 32'h8000_7FFF);
        drive_req0(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 2'b11, 1'b1);
        @(posedge clk);
        #1;
        check_output("w32_rsvd_sat_data", bus.rsp_data, 32'h7FFF_FFFF);
        check_output("w32_rsvd_sat_valid", 32'(bus.rsp0_valid), 32'h1);
        drive_req0(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 2'b11, 1'b0);
        @(posedge clk);
        #1;
        check_output("w32_rsvd_wrap_data", bus.rsp_data, 32'h8000_0000);
        drive_req0(1'b1, 32'h8080_8080, 32'hFFFF_FFFF, 2'b00, 1'b1);
        @(posedge clk);
        #1;
        check_output("lane8_negsat_data", bus.rsp_data, 32'h8080_8080);
        drive_req0(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        @(posedge clk);
        #1;
        check_output("req0_drained", 32'(bus.rsp0_valid), 32'h0);
        bus.rsp0_ready = 1'b0;

        // Contention from a fresh reset: grants alternate 0,1,0,1
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        drive_req0(1'b1, 32'h0000_0010, 32'h0000_0001, 2'b10, 1'b0);
        drive_req1(1'b1, 32'h0000_0020, 32'h0000_0002, 2'b10, 1'b0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_output("rr_req0_ready", 32'(bus.req0_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
            check_output("rr_req1_ready", 32'(bus.req1_ready), (i % 2 == 1) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
            check_output("rr_rsp0_valid", 32'(bus.rsp0_valid), (i % 2 == 0) ? 32'h1 : 32'h0);
            check_output("rr_rsp1_valid", 32'(bus.rsp1_valid), (i % 2 == 1) ? 32'h1 : 32'h0);
            check_output("rr_rsp_data", bus.rsp_data, (i % 2 == 0) ? 32'h0000_0011 : 32'h0000_0022);
        end
        drive_req0(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        drive_req1(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        @(posedge clk);
        #1;
        check_output("rr_drained_rsp0", 32'(bus.rsp0_valid), 32'h0);
        check_output("rr_drained_rsp1", 32'(bus.rsp1_valid), 32'h0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // Backpressure: a stalled owner blocks the other requester
        @(negedge clk);
        drive_req0(1'b1, 32'h0000_0005, 32'h0000_0006, 2'b10, 1'b0);
        @(posedge clk);
        #1;
        drive_req0(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        drive_req1(1'b1, 32'h0000_0030, 32'h0000_0004, 2'b10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("bp_req1_ready_low", 32'(bus.req1_ready), 32'h0);
            check_output("bp_rsp0_held", 32'(bus.rsp0_valid), 32'h1);
        end
        bus.rsp0_ready = 1'b1;
        #1;
        check_output("bp_req1_ready_release", 32'(bus.req1_ready), 32'h1);
        @(posedge clk);
        #1;
        check_output("bp_rsp1_valid", 32'(bus.rsp1_valid), 32'h1);
        check_output("bp_rsp0_valid", 32'(bus.rsp0_valid), 32'h0);
        check_output("bp_rsp_data", bus.rsp_data, 32'h0000_0034);
        drive_req1(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("bp_drained", 32'(bus.rsp1_valid), 32'h0);
        bus.rsp1_ready = 1'b0;

        // Reset while a result is pending discards it
        @(negedge clk);
        drive_req0(1'b1, 32'h0000_0001, 32'h0000_0001, 2'b10, 1'b0);
        @(posedge clk);
        #1;
        drive_req0(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        check_output("mid_pending", 32'(bus.rsp0_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_output("mid_rsp0_cleared", 32'(bus.rsp0_valid), 32'h0);
        check_output("mid_rsp1_cleared", 32'(bus.rsp1_valid), 32'h0);
        check_output("mid_data_cleared", bus.rsp_data, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("post_rst_rsp0", 32'(bus.rsp0_valid), 32'h0);
        check_output("post_rst_rsp1", 32'(bus.rsp1_valid), 32'h0);

        // Grant counters: 20 accepts on requester 0 saturate a 4-bit counter
        @(negedge clk);
        drive_req0(1'b1, 32'h0000_0001, 32'h0000_0002, 2'b10, 1'b0);
        bus.rsp0_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_output("stats_cnt0_mid", 32'(gnt_cnt0), STATS ? 32'hA : 32'h0);
        repeat (10) @(posedge clk);
        #1;
        check_output("stats_cnt0_sat", 32'(gnt_cnt0), STATS ? 32'hF : 32'h0);
        check_output("stats_cnt1", 32'(gnt_cnt1), 32'h0);
        drive_req0(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        @(posedge clk);
        #1;
        bus.rsp0_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks_total, fail_count);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter that shares one packed-SIMD `alu` instance (32-bit add with selectable lane width and optional saturation) between two independent clients. Each client issues operand pairs over a valid/ready request channel. The result is captured in a single output register and returned only on the requesting client's response channel. The block sits between the issue logic of the two clients and the combinational `alu`, which it instantiates internally.

## Interface
Parameters:
- `CNT_W`, 16: width of the per-requester grant counters (used only with `ALU_ARB_STATS_EN`).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  32  operands.
- `req0_width` / `req1_width`  in  2  lane width: 00 = 4×8, 01 = 2×16, 10 = 1×32, 11 = reserved (treated as 10).
- `req0_sat` / `req1_sat`  in  1  saturating add when 1, wrapping add when 0.
- `rsp0_valid` / `rsp1_valid`  out  1  result pending for that requester.
- `rsp0_ready` / `rsp1_ready`  in  1  requester consumes its result.
- `rsp_data`  out  32  shared result bus; valid only qualified by `rsp0_valid` or `rsp1_valid`.
- `gnt_cnt0`, `gnt_cnt1`  out  `CNT_W`  grant counters.

## Operation
- State: result register `res` (32 bits), `res_valid`, `res_owner` (0/1), round-robin pointer `last` (the index most recently granted).
- `rsp_fire` = `res_valid` & `rspX_ready`, where X = `res_owner`.
- `can_accept` = !`res_valid` | `rsp_fire`.
- Grant selection:
  - Only one request valid: grant it.
  - Both valid: grant the one that is not `last`.
  - No request valid: no grant.
- `reqX_ready` = `can_accept` & (grant == X). A ready may assert combinationally on the same cycle as the valid. At most one ready is high per cycle.
- On an accept edge, the arbiter muxes the granted requester's `a`, `b`, `width` and `sat` into the `alu`:
  - `res` ← `alu.c`
  - `res_valid` ← 1
  - `res_owner` ← grant
  - `last` ← grant
- On `rsp_fire` without a new accept: `res_valid` ← 0.
- Simultaneous `rsp_fire` and accept: the new result overwrites `res` and `res_valid` stays 1, giving back-to-back service.
- `rspX_valid` = `res_valid` & (`res_owner` == X). `rsp_data` = `res`.
- A requester's `rsp_ready` has no effect while the other requester owns `res`. A stalled owner blocks both requesters. This is intentional: single outstanding result.
- Requesters must hold the request fields stable while `valid` is high and `ready` is low.

## Timing
- Reset (async assert, sync release): `res`=0, `res_valid`=0, `res_owner`=0, `last`=1 (requester 0 wins the first tie), counters 0. All `rsp*_valid`=0, `rsp_data`=0. Ready outputs follow their combinational equations, so they may assert during reset if `valid` is high, but nothing is captured while `rst_n`=0.
- Latency: request accepted at edge N gives `rspX_valid`=1 and data on `rsp_data` from edge N up to and including the edge that fires the response.
- Throughput: 1 result per cycle while the owner holds `rsp_ready`=1. Both requesters continuously valid alternate 0,1,0,1.
- Reset asserted mid-transaction: the pending result is discarded. No response is produced after reset release.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - `gnt_cnt0` / `gnt_cnt1` increment by 1 on each accept for that requester.
  - Counters saturate at all-ones (no wrap).
- Macro undefined: counter logic is absent and `gnt_cnt0` / `gnt_cnt1` are tied to 0. The port list is identical in both builds.

## Test plan
- Single request, requester 0: a=0x0000_00FF, b=0x0000_0001, width=10, sat=0 -> `req0_ready`=1 the same cycle. Next cycle `rsp0_valid`=1, `rsp_data`=0x0000_0100, `rsp1_valid`=0.
- Lane saturation, requester 1: a=0x7F7F_7F7F, b=0x0101_0101, width=00, sat=1 -> `rsp_data`=0x7F7F_7F7F. The same operands with sat=0 -> 0x8080_8080.
- Contention: both valid every cycle, both `rsp_ready`=1 -> grant order 0,1,0,1 from reset, one response per cycle with the correct `res_owner`.
- Backpressure: requester 0 result pending with `rsp0_ready`=0 for 5 cycles and `req1_valid`=1 -> `req1_ready`=0 throughout. `rsp0_ready`=1 -> requester 1 is accepted the same cycle, and `rsp1_valid`=1 on the next cycle.
- Reset mid-flight: accept a request, drop `rst_n` before `rsp_ready` -> `rsp0_valid`=0 and `rsp1_valid`=0 immediately, and both stay 0 after release.
- Stats: with `ALU_ARB_STATS_EN` defined and `CNT_W`=4, 20 accepts on requester 0 -> `gnt_cnt0`=0xF, `gnt_cnt1`=0. With the macro undefined, both counters read 0.
